// File: rtl/bitserial_alu_ctrl.sv
// bitserial_alu_ctrl
//
// Sequencer that runs WIDTH-bit logic operations through an external, shared
// 1-bit logic slice. A request (op, a, b) is captured on an in_valid/in_ready
// handshake. One operand bit pair per cycle is then presented to the slice,
// LSB first, and each slice output bit is shifted into the result register
// from the top. The finished result is offered on an out_valid/out_ready
// handshake.
//
// Optional feature macro: BSALU_ABORT_EN
//   When defined, an extra input 'abort' cancels an operation in RUN.
//   The default build (macro undefined) has no abort port.
//
// Ports
//   clk        in   1      rising-edge clock
//   rst_n      in   1      synchronous reset, active-low
//   abort      in   1      cancel a running op (BSALU_ABORT_EN only)
//   in_valid   in   1      request valid
//   in_ready   out  1      controller can accept a request (IDLE)
//   op         in   2      00 AND, 01 OR, 10 XOR, 11 NOT(a)
//   a          in   WIDTH  operand A
//   b          in   WIDTH  operand B (ignored for NOT)
//   slice_opA  out  1      op[1] to the slice decoder
//   slice_opB  out  1      op[0] to the slice decoder
//   slice_i0   out  1      current bit of A
//   slice_i1   out  1      current bit of B
//   slice_y    in   1      slice output, combinational from slice_* outputs
//   out_valid  out  1      result valid (DONE)
//   out_ready  in   1      consumer accepts result
//   result     out  WIDTH  completed result
//   busy       out  1      high in RUN or DONE
module bitserial_alu_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
`ifdef BSALU_ABORT_EN
    input  logic             abort,
`endif
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             slice_opA,
    output logic             slice_opB,
    output logic             slice_i0,
    output logic             slice_i1,
    input  logic             slice_y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             busy
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state_q,   state_d;
    logic [1:0]       op_q,      op_d;
    logic [WIDTH-1:0] a_sh_q,    a_sh_d;
    logic [WIDTH-1:0] b_sh_q,    b_sh_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0] result_q,  result_d;
    logic             abort_req;

`ifdef BSALU_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    // Next-state logic: capture in IDLE, shift one bit per cycle in RUN,
    // wait for the consumer in DONE.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        a_sh_d    = a_sh_q;
        b_sh_d    = b_sh_q;
        bit_cnt_d = bit_cnt_q;
        result_d  = result_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    op_d      = op;
                    a_sh_d    = a;
                    b_sh_d    = b;
                    bit_cnt_d = '0;
                    state_d   = ST_RUN;
                end
            end
            ST_RUN: begin
                if (abort_req) begin
                    // Cancelled ops leave no partial result behind.
                    result_d  = '0;
                    bit_cnt_d = '0;
                    state_d   = ST_IDLE;
                end else begin
                    // LSB-first operands, so each new bit enters at the MSB and
                    // after WIDTH shifts bit k sits at position k.
                    result_d = {slice_y, result_q[WIDTH-1:1]};
                    a_sh_d   = a_sh_q >> 1;
                    b_sh_d   = b_sh_q >> 1;
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = ST_DONE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            op_q      <= '0;
            a_sh_q    <= '0;
            b_sh_q    <= '0;
            bit_cnt_q <= '0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            a_sh_q    <= a_sh_d;
            b_sh_q    <= b_sh_d;
            bit_cnt_q <= bit_cnt_d;
            result_q  <= result_d;
        end
    end

    // Operand bits reach the slice only while running; the opcode lines
    // always reflect the last captured op.
    assign slice_opA = op_q[1];
    assign slice_opB = op_q[0];
    assign slice_i0  = (state_q == ST_RUN) & a_sh_q[0];
    assign slice_i1  = (state_q == ST_RUN) & b_sh_q[0];

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q == ST_RUN) | (state_q == ST_DONE);
    assign result    = result_q;

endmodule
